mem_req_server: RTL
===================

# mem_req_server

Memory-side responder for the vector-add accelerator's single-word request port (MEM_A/MEM_RE/MEM_WE/MEM_D/MEM_Q/MEM_BUSY/MEM_DONE). It sits directly downstream of the accelerator and services its reads and writes from an internal word array with fixed, parameterised latency. A second, lower-rate host port shares the array under round-robin arbitration so a testbench or CPU can preload operands and read back results.

## Interface
- WA, 32, address width (both ports)
- WD, 32, data width
- DEPTH, 4096, array size in words; power of two
- ADDR_LSB, 5, byte-address shift; word index = A >> ADDR_LSB
- LATENCY, 4, cycles from accept to DONE/ACK; legal range ≥1
- CLK  in  1  clock; all logic on posedge
- RST_X  in  1  synchronous active-low reset, sampled on posedge CLK
- MEM_A  in  WA  accelerator byte address
- MEM_RE  in  1  accelerator read request (level)
- MEM_WE  in  1  accelerator write request (level)
- MEM_D  in  WD  accelerator write data
- MEM_Q  out  WD  read data; valid in the MEM_DONE cycle, held until the next accelerator read completes
- MEM_BUSY  out  1  accelerator transaction in progress
- MEM_DONE  out  1  one-cycle completion pulse
- HOST_REQ  in  1  host request (level)
- HOST_WE  in  1  host write (1) / read (0), qualified by HOST_REQ
- HOST_A  in  WA  host byte address
- HOST_D  in  WD  host write data
- HOST_Q  out  WD  host read data; valid in the HOST_ACK cycle, then held
- HOST_ACK  out  1  one-cycle host completion pulse
- ERR  out  1  sticky error flag (see Configuration)

## Operation
- States: IDLE, WAIT, RESP. Internal: owner (ACC/HOST), last_grant, countdown, captured A/D/op, armed_acc, armed_host.
- Request detection: accelerator pending = (MEM_RE|MEM_WE) & armed_acc; host pending = HOST_REQ & armed_host. armed_x clears on acceptance from port x; it sets again in any cycle that port's request is sampled low. A held request therefore never issues twice; the accelerator's RE stays high for several cycles after BUSY rises and must not be serviced again.
- IDLE: if exactly one port is pending, grant it. If both are pending, grant the port opposite last_grant. On accept, capture address, data and op. Set countdown = LATENCY-1. Go to WAIT, or to RESP directly when LATENCY=1.
- Accelerator op: MEM_WE=1 is a write; otherwise it is a read. If MEM_RE and MEM_WE are both 1, the write is performed and the read is dropped.
- WAIT: decrement countdown; at 0 go to RESP.
- RESP (one cycle): a write commits to the array at this edge; a read loads MEM_Q/HOST_Q from the array. Pulse DONE/ACK for the owner. Update last_grant. Return to IDLE.
- A new request can be accepted in the IDLE cycle after RESP.
- MEM_BUSY = 1 in WAIT and RESP when owner=ACC; it stays 0 during host transactions.
- Reset (including mid-transaction): state IDLE; any in-flight write is discarded and never committed. MEM_BUSY/MEM_DONE/HOST_ACK/ERR=0; MEM_Q/HOST_Q=0; armed_acc=armed_host=1; last_grant=HOST. Array contents are not reset.

## Timing
- Accept at edge E (IDLE, pending).
- BUSY rises at E+1.
- DONE/ACK is high in cycle E+LATENCY only.
- BUSY falls at E+LATENCY+1.
- Read data is visible in the DONE/ACK cycle. The accelerator latches MEM_Q on the edge closing that cycle.
- Back-to-back throughput: one transaction per LATENCY+1 cycles.
- No combinational path from any input to any output.

## Configuration
- MEMSRV_ERR_EN defined:
  - Index ≥ DEPTH: no write is committed; a read returns 0.
  - Simultaneous MEM_RE & MEM_WE: the write still wins.
  - Either condition sets ERR, which stays set until reset.
- MEMSRV_ERR_EN undefined:
  - The index is truncated to log2(DEPTH) bits (wraps).
  - ERR is constant 0.

## Test plan
- Host write 0x0000_0011 @0x0, host read @0x0 (LATENCY=4) -> HOST_ACK exactly 4 cycles after accept, HOST_Q=0x11, MEM_BUSY never 1.
- Accelerator holds MEM_RE=1 @0x20 for 4 cycles, array[1]=0xABCD -> exactly one transaction; MEM_BUSY cycles E+1..E+4; MEM_DONE only at E+4 with MEM_Q=0xABCD; no second BUSY until RE drops and re-rises.
- Preload word0=5, word1024=7 via host; run the full accelerator vector add (SIZE=32768) -> word2048 reads 12 via host; accelerator reaches done.
- HOST_REQ and MEM_RE rise on the same edge, last_grant=HOST -> accelerator served first, host accepted the IDLE cycle after MEM_DONE; the next tie goes to host.
- RST_X low during WAIT of an accelerator write 0x99 @0x40 -> all outputs 0 next cycle; a host read @0x40 returns the prior value.
- MEMSRV_ERR_EN defined, MEM_RE @ DEPTH<<ADDR_LSB -> MEM_Q=0, ERR=1 and sticky. Undefined -> reads word 0, ERR=0.

Source files
------------

// File: rtl/mem_req_server.sv
// mem_req_server: fixed-latency word array serving the accelerator port and a
// round-robin host port. Define MEMSRV_ERR_EN for range checks and sticky ERR.
module mem_req_server #(
  parameter int WA       = 32,
  parameter int WD       = 32,
  parameter int DEPTH    = 4096,
  parameter int ADDR_LSB = 5,
  parameter int LATENCY  = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [WA-1:0] MEM_A,
  input  logic          MEM_RE,
  input  logic          MEM_WE,
  input  logic [WD-1:0] MEM_D,
  output logic [WD-1:0] MEM_Q,
  output logic          MEM_BUSY,
  output logic          MEM_DONE,
  input  logic          HOST_REQ,
  input  logic          HOST_WE,
  input  logic [WA-1:0] HOST_A,
  input  logic [WD-1:0] HOST_D,
  output logic [WD-1:0] HOST_Q,
  output logic          HOST_ACK,
  output logic          ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic OWN_ACC  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic          owner;
  logic          last_grant;
  logic          armed_acc;
  logic          armed_host;
  logic [CW-1:0] cnt;

  logic [AW-1:0] cap_idx;
  logic [WD-1:0] cap_d;
  logic          cap_we;
  logic          cap_oob;

  logic [WD-1:0] mem [DEPTH];
  logic [WD-1:0] mem_q;
  logic [WD-1:0] host_q;
  logic          err;

  logic          acc_req;
  logic          acc_pend;
  logic          host_pend;
  logic          grant_acc;
  logic          grant_host;
  logic          accept;
  logic          to_resp;

  logic [WA-1:0] sel_a;
  logic [WA-1:0] sel_word;
  logic [AW-1:0] sel_idx;
  logic [WD-1:0] sel_d;
  logic          sel_we;
  logic          sel_oob;
  logic          sel_err;

  logic [AW-1:0] eff_idx;
  logic [WD-1:0] eff_d;
  logic          eff_we;
  logic          eff_oob;
  logic          eff_own;
  logic          wr_en;
  logic          rd_en;
  logic [WD-1:0] rd_data;

  // A port is pending only while re-armed by a low sample since its last grant.
  assign acc_req   = MEM_RE | MEM_WE;
  assign acc_pend  = acc_req & armed_acc;
  assign host_pend = HOST_REQ & armed_host;
  assign accept    = grant_acc | grant_host;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and grant: a tie goes to the port not served last.
  always_comb begin
    state_nx   = state;
    grant_acc  = 1'b0;
    grant_host = 1'b0;
    to_resp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc_pend && host_pend) begin
          grant_host = (last_grant == OWN_ACC);
          grant_acc  = (last_grant == OWN_HOST);
        end else begin
          grant_acc  = acc_pend;
          grant_host = host_pend;
        end
        if (acc_pend || host_pend) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
            to_resp  = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_ONE) begin
          state_nx = RESP;
          to_resp  = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Select the granted port's request and derive its word index.
  always_comb begin
    sel_a    = grant_host ? HOST_A  : MEM_A;
    sel_d    = grant_host ? HOST_D  : MEM_D;
    sel_we   = grant_host ? HOST_WE : MEM_WE;
    sel_word = sel_a >> ADDR_LSB;
    sel_idx  = sel_word[AW-1:0];
`ifdef MEMSRV_ERR_EN
    sel_oob  = (sel_word >= WA'(DEPTH));
    sel_err  = sel_oob | (grant_acc & MEM_RE & MEM_WE);
`else
    sel_oob  = 1'b0;
    sel_err  = 1'b0;
`endif
  end

`ifndef MEMSRV_ERR_EN
  logic unused_hi;
  assign unused_hi = ^sel_word[WA-1:AW];
`endif

  // With a one-cycle latency the array is touched on the accept edge itself.
  assign eff_idx = (state == IDLE) ? sel_idx    : cap_idx;
  assign eff_d   = (state == IDLE) ? sel_d      : cap_d;
  assign eff_we  = (state == IDLE) ? sel_we     : cap_we;
  assign eff_oob = (state == IDLE) ? sel_oob    : cap_oob;
  assign eff_own = (state == IDLE) ? grant_host : owner;

  assign wr_en   = to_resp & eff_we & ~eff_oob & RST_X;
  assign rd_en   = to_resp & ~eff_we;
  assign rd_data = eff_oob ? '0 : mem[eff_idx];

  // Capture, countdown, arbitration history, re-arming and sticky error.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      owner      <= OWN_ACC;
      last_grant <= OWN_HOST;
      cnt        <= '0;
      cap_idx    <= '0;
      cap_d      <= '0;
      cap_we     <= 1'b0;
      cap_oob    <= 1'b0;
      armed_acc  <= 1'b1;
      armed_host <= 1'b1;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= grant_host;
        cap_idx <= sel_idx;
        cap_d   <= sel_d;
        cap_we  <= sel_we;
        cap_oob <= sel_oob;
        cnt     <= CNT_INIT;
        if (sel_err) begin
          err <= 1'b1;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_ONE;
      end
      if (state == RESP) begin
        last_grant <= owner;
      end
      if (grant_acc) begin
        armed_acc <= 1'b0;
      end else if (!acc_req) begin
        armed_acc <= 1'b1;
      end
      if (grant_host) begin
        armed_host <= 1'b0;
      end else if (!HOST_REQ) begin
        armed_host <= 1'b1;
      end
    end
  end

  // Word array; contents survive reset, in-flight writes do not.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[eff_idx] <= eff_d;
    end
  end

  // Read data registers, loaded as the transaction enters its response cycle.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      mem_q  <= '0;
      host_q <= '0;
    end else if (rd_en) begin
      if (eff_own == OWN_HOST) begin
        host_q <= rd_data;
      end else begin
        mem_q <= rd_data;
      end
    end
  end

  assign MEM_BUSY = (state != IDLE) & (owner == OWN_ACC);
  assign MEM_DONE = (state == RESP) & (owner == OWN_ACC);
  assign HOST_ACK = (state == RESP) & (owner == OWN_HOST);
  assign MEM_Q    = mem_q;
  assign HOST_Q   = host_q;
  assign ERR      = err;

endmodule
